// File: rtl/hazard_tracker_pkg.sv
// Shared constants, stage-record type and Tnew helpers for the hazard tracker.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_E     = 2'b01;
    localparam logic [1:0] FWD_M     = 2'b10;
    localparam logic [1:0] FWD_W     = 2'b11;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Records carry a3 at a fixed maximum width so the type can live here.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic [REG_AW_MAX-1:0] a3;
        logic                  we;
        logic [1:0]            tnew;
    } stage_rec_t;

    typedef enum logic {
        TNEW_DEC,
        TNEW_ZERO
    } tnew_op_e;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic rec_hit(input stage_rec_t r, input logic [REG_AW_MAX-1:0] addr);
        return r.we && (r.a3 != '0) && (r.a3 == addr);
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// D-stage decode info in, stall and forwarding selects out.
interface hazard_tracker_if #(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic [1:0]        tuse_rs_d;
    logic [1:0]        tuse_rt_d;
    logic [REG_AW-1:0] a3_d;
    logic              we_d;
    logic [1:0]        tnew_d;
    logic              stall;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/hazard_tracker_stage_reg.sv
// One pipeline stage record; tnew sits in the two LSBs of the packed word.
module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter int unsigned W       = $bits(stage_rec_t),
    parameter tnew_op_e    TNEW_OP = TNEW_DEC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble_i,
    input  logic [W-1:0] rec_i,
    output logic [W-1:0] rec_o
);

    logic [W-1:0] rec_q;
    logic [W-1:0] rec_d;

    always_comb begin
        rec_d = rec_i;
        rec_d[1:0] = (TNEW_OP == TNEW_ZERO) ? 2'd0 : tnew_dec(rec_i[1:0]);
        if (bubble_i) begin
            rec_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/hazard_tracker.sv
// Stall and forwarding-select generation from E/M/W destination records.
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    hazard_tracker_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    localparam int unsigned RW = $bits(stage_rec_t);
    localparam int unsigned EW = RW + 2 * REG_AW;

    stage_rec_t            d_rec;
    stage_rec_t            rec_e;
    stage_rec_t            rec_m;
    stage_rec_t            rec_w;
    logic [REG_AW-1:0]     rs_e;
    logic [REG_AW-1:0]     rt_e;
    logic [EW-1:0]         e_word;
    logic                  stall;

    function automatic logic op_stall(input logic [REG_AW_MAX-1:0] a, input logic [1:0] tuse,
                                      input stage_rec_t e, input stage_rec_t m);
        if (a == '0 || tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (rec_hit(e, a) && (e.tnew > tuse)) || (rec_hit(m, a) && (m.tnew > tuse));
    endfunction

    // The nearest live producer wins even when it is not ready yet; older copies are stale.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW_MAX-1:0] a, input logic use_e,
                                           input stage_rec_t e, input stage_rec_t m,
                                           input stage_rec_t w);
        if (a == '0) begin
            return FWD_RF;
        end
        if (use_e && rec_hit(e, a)) begin
            return (e.tnew == 2'd0) ? FWD_E : FWD_RF;
        end
        if (rec_hit(m, a)) begin
            return (m.tnew == 2'd0) ? FWD_M : FWD_RF;
        end
        if (rec_hit(w, a)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        d_rec      = '0;
        d_rec.a3   = REG_AW_MAX'(hz.a3_d);
        d_rec.we   = hz.we_d;
        d_rec.tnew = hz.tnew_d;
    end

    hazard_stage_reg #(.W(EW), .TNEW_OP(TNEW_DEC)) u_stage_e (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (stall),
        .rec_i    ({hz.rs_d, hz.rt_d, d_rec}),
        .rec_o    (e_word)
    );

    assign {rs_e, rt_e, rec_e} = e_word;

    hazard_stage_reg #(.W(RW), .TNEW_OP(TNEW_DEC)) u_stage_m (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (1'b0),
        .rec_i    (rec_e),
        .rec_o    (rec_m)
    );

    hazard_stage_reg #(.W(RW), .TNEW_OP(TNEW_ZERO)) u_stage_w (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (1'b0),
        .rec_i    (rec_m),
        .rec_o    (rec_w)
    );

    always_comb begin
        stall = op_stall(REG_AW_MAX'(hz.rs_d), hz.tuse_rs_d, rec_e, rec_m)
              | op_stall(REG_AW_MAX'(hz.rt_d), hz.tuse_rt_d, rec_e, rec_m);
        hz.stall    = stall;
        hz.fwd_rs_d = fwd_sel(REG_AW_MAX'(hz.rs_d), 1'b1, rec_e, rec_m, rec_w);
        hz.fwd_rt_d = fwd_sel(REG_AW_MAX'(hz.rt_d), 1'b1, rec_e, rec_m, rec_w);
        hz.fwd_rs_e = fwd_sel(REG_AW_MAX'(rs_e), 1'b0, '0, rec_m, rec_w);
        hz.fwd_rt_e = fwd_sel(REG_AW_MAX'(rt_e), 1'b0, '0, rec_m, rec_w);
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Pipeline hazard tracker for the five-stage MIPS core: consumes the per-instruction Tuse/Tnew/destination information produced by the D-stage signal decoder, carries it down the E, M and W stages in its own shift registers, and each cycle produces the D-stage stall request and the forwarding-mux selects for the D-stage and E-stage operand readers. It sits between the decoder and the pipeline registers/forwarding muxes; PC, D-register enable and the E-register bubble are driven from `stall`.

## Interface
- `REG_AW`, default 5: register-address width.
- `clk  in  1`: core clock.
- `reset  in  1`: synchronous, active-high reset.
- `rs_d  in  REG_AW`: D-stage source register 1 address.
- `rt_d  in  REG_AW`: D-stage source register 2 address.
- `tuse_rs_d  in  2`: cycles until `rs_d` is needed; 3 means unused.
- `tuse_rt_d  in  2`: cycles until `rt_d` is needed; 3 means unused.
- `a3_d  in  REG_AW`: D-stage destination address, already resolved from RegDst.
- `we_d  in  1`: D-stage RegWrite, already qualified by the branch condition.
- `tnew_d  in  2`: D-stage Tnew.
- `stall  out  1`: freeze PC and the D register, and insert a bubble into E.
- `fwd_rs_d`, `fwd_rt_d  out  2`: D-operand select. 00 = register file, 01 = E, 10 = M, 11 = W.
- `fwd_rs_e`, `fwd_rt_e  out  2`: E-operand select. 00 = E register value, 10 = M, 11 = W.
- `stall_count  out  32`: present only with `HAZARD_STATS_EN`.

## Operation
- Three stage records are kept: E, M and W. Each record holds {a3, we, tnew}. The E record additionally holds {rs, rt}.
- A record is *live* when `we` = 1 and `a3` ≠ 0.
- **Advance, every cycle:**
  - W ← M, with tnew forced to 0.
  - M ← E, with tnew = sat0(tnewE − 1).
  - If `stall` = 0: E ← {a3_d, we_d, sat0(tnew_d − 1), rs_d, rt_d}.
  - If `stall` = 1: E ← bubble (all fields 0).
- **Stall (combinational):** for each operand X ∈ {rs, rt} with address ≠ 0 and tuse_X ≠ 3, X stalls if either:
  - the E record is live, a3E = X and tnewE > tuse_X; or
  - the M record is live, a3M = X and tnewM > tuse_X.
  - `stall` = stall_rs | stall_rt.
- **D forwarding for operand X (address ≠ 0), in strict priority order:**
  1. E record live with a3E = X: select 01 if tnewE = 0, else 00. Lower stages are not consulted; their value is stale.
  2. M record live with a3M = X: select 10 if tnewM = 0, else 00.
  3. W record live with a3W = X: select 11.
  4. Otherwise 00.
- **E forwarding:** same rule applied to the E record's rs/rt, using the M then W records only. No E entry is possible.
- Address 0 never stalls and never forwards.
- Tnew arithmetic is 2-bit, saturating at 0.

## Timing
- `stall` and all `fwd_*` outputs are combinational from current inputs and records. There is zero latency.
- Records update on the rising `clk` edge.
- **Reset:** all records are cleared. `stall` = 0, all `fwd_*` = 00, `stall_count` = 0.
- **Reset mid-stall:** on the next cycle the records are empty, so `stall` = 0 regardless of the D inputs unless a new conflict exists.
- A stall lasts at most 2 consecutive cycles, for a load followed by a Tuse-0 consumer.
- `stall` is asserted while the D inputs remain held by the frozen D register. No handshake beyond this applies.

## Configuration
- `HAZARD_STATS_EN` defined:
  - 32-bit `stall_count` increments on every cycle with `stall` = 1 and saturates at 0xFFFF_FFFF.
  - Cleared by `reset`.
- Not defined: the port and the counter are absent, with no other change in behaviour.

## Structure
- Package `hazard_pkg` holds:
  - constants FWD_RF = 2'b00, FWD_E = 2'b01, FWD_M = 2'b10, FWD_W = 2'b11;
  - TUSE_NONE = 2'd3;
  - the stage-record typedef {a3, we, tnew}.
- One sub-module, `hazard_stage_reg`: a single record register with synchronous clear, bubble insert and decrement-on-load. It is instantiated three times; the E instance is widened with rs/rt.

## Test plan
- lw $t0 (tnew_d = 3) then add using $t0 (tuse = 1): `stall` = 1 for 1 cycle; next cycle `fwd_rs_d` = 00; when the add is in E, `fwd_rs_e` = 10 is not allowed (tnewM = 1) and `fwd_rs_e` = 11 is required.
- lw $t0 then beq on $t0 (tuse = 0): `stall` = 1 for exactly 2 cycles, then `fwd_rs_d` = 11.
- add $t1 (tnew_d = 2) then beq on $t1: 1 stall cycle, then `fwd_rt_d` = 10.
- jal (a3 = 31, tnew_d = 0 → tnewE = 0) then jr $31 (tuse 0): `stall` = 0 and `fwd_rs_d` = 01.
- Write to $0 with tnew_d = 3, then a consumer reading $0: `stall` = 0 and all forwards = 00.
- Reset asserted during a load-use stall: next cycle `stall` = 0 and all `fwd_*` = 00. With `HAZARD_STATS_EN`, `stall_count` reads 0, then counts 3 after three stall cycles.
